// File: rtl/oob_dev.sv
// oob_dev: device-side SATA out-of-band (OOB) link bring-up for a GTX transceiver.
// Handles COMINIT/COMWAKE signalling, ALIGNp/SYNCp exchange and per-state
// timeouts, then passes the upper-layer transmit stream through once the link is up.
// Receive-side detectors and data are registered once before use.
// Optional feature: define OOB_DEV_RETRY_EN to retry the sequence up to three
// times after a timeout before reporting oob_error.
module oob_dev #(
    parameter int DATA_BYTE_WIDTH = 4,
    parameter int TIMEOUT_CYCLES  = 131070
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dev_start,
    input  logic        rxcominitdet_in,
    input  logic        rxcomwakedet_in,
    input  logic        rxelecidle_in,
    output logic        txcominit,
    output logic        txcomwake,
    output logic        txelecidle,
    input  logic [31:0] txdata_in,
    input  logic [3:0]  txcharisk_in,
    output logic [31:0] txdata_out,
    output logic [3:0]  txcharisk_out,
    input  logic [31:0] rxdata_in,
    input  logic [3:0]  rxcharisk_in,
    output logic [31:0] rxdata_out,
    output logic [3:0]  rxcharisk_out,
    output logic        link_up,
    output logic        oob_error,
    output logic [2:0]  oob_state
);

    // Only a 4-byte GTX interface is supported; anything else is a build error.
    if (DATA_BYTE_WIDTH != 4) begin : g_bad_width
        $fatal(1, "oob_dev: DATA_BYTE_WIDTH must be 4");
    end

    // The timeout must fit the 20-bit state timer.
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 1048576)) begin : g_bad_timeout
        $fatal(1, "oob_dev: TIMEOUT_CYCLES out of range for 20-bit timer");
    end

    localparam logic [31:0] ALIGN_P      = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC_P       = 32'hB5B5957C;
    localparam logic [3:0]  PRIM_K       = 4'h1;
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_COMINIT      = 3'd1,
        ST_WAIT_COMWAKE = 3'd2,
        ST_COMWAKE      = 3'd3,
        ST_SEND_ALIGN   = 3'd4,
        ST_SEND_SYNC    = 3'd5,
        ST_LINKUP       = 3'd6,
        ST_ERROR        = 3'd7
    } state_t;

    // ALIGNp is recognised only with its K-character flag on byte 0 alone.
    function automatic logic is_align(input logic [31:0] d, input logic [3:0] k);
        return (d == ALIGN_P) && (k == PRIM_K);
    endfunction

    // A word counts toward SYNC detection when byte 0 is a K-character and it is not ALIGNp.
    function automatic logic is_sync_cand(input logic [31:0] d, input logic [3:0] k);
        return k[0] && !is_align(d, k);
    endfunction

    // Registered receive side
    logic        rxcominitdet_r;
    logic        rxcomwakedet_r;
    logic        rxelecidle_r;
    logic [31:0] rxdata_r;
    logic [3:0]  rxcharisk_r;

    // FSM state and its counters
    state_t      state_r;
    state_t      state_nxt_s;
    logic [19:0] timer_r;
    logic [19:0] timer_nxt_s;
    logic [1:0]  sync_cnt_r;
    logic [1:0]  sync_cnt_nxt_s;
    logic        timeout_s;
    logic        oob_error_nxt_s;
`ifdef OOB_DEV_RETRY_EN
    logic [1:0]  retry_r;
    logic [1:0]  retry_nxt_s;
`endif

    // Registered outputs
    logic        txcominit_r;
    logic        txcomwake_r;
    logic        txelecidle_r;
    logic        link_up_r;
    logic        oob_error_r;
    logic [31:0] txdata_r;
    logic [3:0]  txcharisk_r;

    // Electrical-idle detection is captured for the record but does not steer the sequence.
    logic        unused_s;
    assign unused_s = rxelecidle_r;

    // Capture all GTX receive inputs once before they are used anywhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxcominitdet_r <= 1'b0;
            rxcomwakedet_r <= 1'b0;
            rxelecidle_r   <= 1'b0;
            rxdata_r       <= 32'd0;
            rxcharisk_r    <= 4'd0;
        end else begin
            rxcominitdet_r <= rxcominitdet_in;
            rxcomwakedet_r <= rxcomwakedet_in;
            rxelecidle_r   <= rxelecidle_in;
            rxdata_r       <= rxdata_in;
            rxcharisk_r    <= rxcharisk_in;
        end
    end

    // Next-state, timer, SYNC-count and retry decisions; host COMINIT beats a timeout.
    always_comb begin
        state_nxt_s    = state_r;
        sync_cnt_nxt_s = 2'd0;
        timeout_s      = (timer_r == TIMEOUT_LAST);
        case (state_r)
            ST_IDLE: begin
                if (rxcominitdet_r || dev_start) begin
                    state_nxt_s = ST_COMINIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COMINIT: begin
                state_nxt_s = ST_WAIT_COMWAKE;
            end
            ST_WAIT_COMWAKE: begin
                if (rxcominitdet_r) begin
                    state_nxt_s = ST_COMINIT;
                end else if (timeout_s) begin
                    state_nxt_s = ST_ERROR;
                end else if (rxcomwakedet_r) begin
                    state_nxt_s = ST_COMWAKE;
                end else begin
                    state_nxt_s = ST_WAIT_COMWAKE;
                end
            end
            ST_COMWAKE: begin
                if (rxcominitdet_r) begin
                    state_nxt_s = ST_COMINIT;
                end else begin
                    state_nxt_s = ST_SEND_ALIGN;
                end
            end
            ST_SEND_ALIGN: begin
                if (rxcominitdet_r) begin
                    state_nxt_s = ST_COMINIT;
                end else if (timeout_s) begin
                    state_nxt_s = ST_ERROR;
                end else if (is_align(rxdata_r, rxcharisk_r)) begin
                    state_nxt_s = ST_SEND_SYNC;
                end else begin
                    state_nxt_s = ST_SEND_ALIGN;
                end
            end
            ST_SEND_SYNC: begin
                if (rxcominitdet_r) begin
                    state_nxt_s = ST_COMINIT;
                end else if (timeout_s) begin
                    state_nxt_s = ST_ERROR;
                end else if (is_sync_cand(rxdata_r, rxcharisk_r)) begin
                    if (sync_cnt_r == 2'd2) begin
                        state_nxt_s = ST_LINKUP;
                    end else begin
                        state_nxt_s    = ST_SEND_SYNC;
                        sync_cnt_nxt_s = sync_cnt_r + 2'd1;
                    end
                end else begin
                    state_nxt_s = ST_SEND_SYNC;
                end
            end
            ST_LINKUP: begin
                if (rxcominitdet_r) begin
                    state_nxt_s = ST_COMINIT;
                end else begin
                    state_nxt_s = ST_LINKUP;
                end
            end
            ST_ERROR: begin
                if (rxcominitdet_r) begin
                    state_nxt_s = ST_COMINIT;
`ifdef OOB_DEV_RETRY_EN
                end else if (retry_r != 2'd3) begin
                    state_nxt_s = ST_COMINIT;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Timer restarts on any state change and only runs in the waiting states.
        if (state_nxt_s != state_r) begin
            timer_nxt_s = 20'd0;
        end else if ((state_r == ST_WAIT_COMWAKE) || (state_r == ST_SEND_ALIGN) ||
                     (state_r == ST_SEND_SYNC)) begin
            timer_nxt_s = timer_r + 20'd1;
        end else begin
            timer_nxt_s = 20'd0;
        end

`ifdef OOB_DEV_RETRY_EN
        // Only the final timeout, after three retries, is reported.
        oob_error_nxt_s = (state_nxt_s == ST_ERROR) && (retry_r == 2'd3);
        if ((state_nxt_s == ST_IDLE) || (state_nxt_s == ST_LINKUP)) begin
            retry_nxt_s = 2'd0;
        end else if ((state_r == ST_ERROR) && (state_nxt_s == ST_COMINIT) && !rxcominitdet_r) begin
            retry_nxt_s = retry_r + 2'd1;
        end else begin
            retry_nxt_s = retry_r;
        end
`else
        oob_error_nxt_s = (state_nxt_s == ST_ERROR);
`endif
    end

    // OOB state machine registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            timer_r    <= 20'd0;
            sync_cnt_r <= 2'd0;
`ifdef OOB_DEV_RETRY_EN
            retry_r    <= 2'd0;
`endif
        end else begin
            state_r    <= state_nxt_s;
            timer_r    <= timer_nxt_s;
            sync_cnt_r <= sync_cnt_nxt_s;
`ifdef OOB_DEV_RETRY_EN
            retry_r    <= retry_nxt_s;
`endif
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txcominit_r  <= 1'b0;
            txcomwake_r  <= 1'b0;
            txelecidle_r <= 1'b1;
            link_up_r    <= 1'b0;
            oob_error_r  <= 1'b0;
            txdata_r     <= 32'd0;
            txcharisk_r  <= 4'd0;
        end else begin
            txcominit_r <= (state_nxt_s == ST_COMINIT);
            txcomwake_r <= (state_nxt_s == ST_COMWAKE);
            link_up_r   <= (state_nxt_s == ST_LINKUP);
            oob_error_r <= oob_error_nxt_s;
            case (state_nxt_s)
                ST_IDLE, ST_COMINIT, ST_WAIT_COMWAKE, ST_ERROR: begin
                    txelecidle_r <= 1'b1;
                    txdata_r     <= 32'd0;
                    txcharisk_r  <= 4'd0;
                end
                ST_COMWAKE: begin
                    txelecidle_r <= 1'b0;
                    txdata_r     <= 32'd0;
                    txcharisk_r  <= 4'd0;
                end
                ST_SEND_ALIGN: begin
                    txelecidle_r <= 1'b0;
                    txdata_r     <= ALIGN_P;
                    txcharisk_r  <= PRIM_K;
                end
                ST_SEND_SYNC: begin
                    txelecidle_r <= 1'b0;
                    txdata_r     <= SYNC_P;
                    txcharisk_r  <= PRIM_K;
                end
                ST_LINKUP: begin
                    txelecidle_r <= 1'b0;
                    txdata_r     <= txdata_in;
                    txcharisk_r  <= txcharisk_in;
                end
                default: begin
                    txelecidle_r <= 1'b1;
                    txdata_r     <= 32'd0;
                    txcharisk_r  <= 4'd0;
                end
            endcase
        end
    end

    assign txcominit     = txcominit_r;
    assign txcomwake     = txcomwake_r;
    assign txelecidle    = txelecidle_r;
    assign link_up       = link_up_r;
    assign oob_error     = oob_error_r;
    assign txdata_out    = txdata_r;
    assign txcharisk_out = txcharisk_r;
    assign rxdata_out    = rxdata_r;
    assign rxcharisk_out = rxcharisk_r;
    assign oob_state     = state_r;

endmodule

// File: tb/tb_oob_dev.sv
// Directed testbench for oob_dev: link bring-up, SYNC counting, link loss,
// timeout, COMINIT-over-timeout priority, dev_start gating and async reset.
module tb_oob_dev;

    localparam int          TMO    = 200;
    localparam logic [31:0] ALIGNW = 32'h7B4A4ABC;
    localparam logic [31:0] SYNCW  = 32'hB5B5957C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dev_start = 1'b0;
    logic        rxcominitdet_in = 1'b0;
    logic        rxcomwakedet_in = 1'b0;
    logic        rxelecidle_in = 1'b0;
    logic        txcominit, txcomwake, txelecidle;
    logic [31:0] txdata_in = 32'd0;
    logic [3:0]  txcharisk_in = 4'd0;
    logic [31:0] txdata_out;
    logic [3:0]  txcharisk_out;
    logic [31:0] rxdata_in = 32'd0;
    logic [3:0]  rxcharisk_in = 4'd0;
    logic [31:0] rxdata_out;
    logic [3:0]  rxcharisk_out;
    logic        link_up, oob_error;
    logic [2:0]  oob_state;

    int total_cnt = 0;
    int bad_cnt   = 0;

    oob_dev #(.DATA_BYTE_WIDTH(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .dev_start(dev_start),
        .rxcominitdet_in(rxcominitdet_in), .rxcomwakedet_in(rxcomwakedet_in),
        .rxelecidle_in(rxelecidle_in),
        .txcominit(txcominit), .txcomwake(txcomwake), .txelecidle(txelecidle),
        .txdata_in(txdata_in), .txcharisk_in(txcharisk_in),
        .txdata_out(txdata_out), .txcharisk_out(txcharisk_out),
        .rxdata_in(rxdata_in), .rxcharisk_in(rxcharisk_in),
        .rxdata_out(rxdata_out), .rxcharisk_out(rxcharisk_out),
        .link_up(link_up), .oob_error(oob_error), .oob_state(oob_state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input logic [31:0] d, input logic [3:0] k);
        rxdata_in    = d;
        rxcharisk_in = k;
    endtask

    // From WAIT_COMWAKE: host COMWAKE, leaves the DUT in SEND_ALIGN
    task automatic to_send_align();
        rxcomwakedet_in = 1'b1;
        tick();
        rxcomwakedet_in = 1'b0;
        tick();
        tick();
    endtask

    // Watchdog: the run must never hang
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] words [6];
        int hold_bad;

        // Reset with live inputs: input registers must still read 0
        txdata_in    = 32'hDEADBEEF;
        txcharisk_in = 4'hF;
        set_rx(32'hA5A5A5A5, 4'h1);
        repeat (3) tick();
        check_val("rst_state", oob_state, 3'd0);
        check_val("rst_elecidle", txelecidle, 1'b1);
        check_val("rst_cominit", txcominit, 1'b0);
        check_val("rst_comwake", txcomwake, 1'b0);
        check_val("rst_linkup", link_up, 1'b0);
        check_val("rst_error", oob_error, 1'b0);
        check_val("rst_txdata", txdata_out, 32'd0);
        check_val("rst_txk", txcharisk_out, 4'd0);
        check_val("rst_rxdata", rxdata_out, 32'd0);
        rst_n = 1'b1;
        set_rx(32'd0, 4'd0);
        tick();
        check_val("idle_txdata", txdata_out, 32'd0);

        // Full bring-up: COMINIT at +2 cycles
        rxcominitdet_in = 1'b1;
        tick();
        rxcominitdet_in = 1'b0;
        check_val("cominit_lat1", txcominit, 1'b0);
        tick();
        check_val("cominit_lat2", txcominit, 1'b1);
        check_val("cominit_state", oob_state, 3'd1);
        check_val("cominit_eidle", txelecidle, 1'b1);
        tick();
        check_val("cominit_one", txcominit, 1'b0);
        check_val("wait_state", oob_state, 3'd2);
        check_val("wait_eidle", txelecidle, 1'b1);
        repeat (97) tick();
        check_val("wait_100", oob_state, 3'd2);
        rxcomwakedet_in = 1'b1;
        tick();
        rxcomwakedet_in = 1'b0;
        check_val("comwake_reg", oob_state, 3'd2);
        tick();
        check_val("comwake_state", oob_state, 3'd3);
        check_val("comwake_tx", txcomwake, 1'b1);
        check_val("comwake_eidle", txelecidle, 1'b0);
        check_val("comwake_data", txdata_out, 32'd0);
        tick();
        check_val("comwake_one", txcomwake, 1'b0);
        check_val("align_state", oob_state, 3'd4);
        check_val("align_tx", txdata_out, ALIGNW);
        check_val("align_k", txcharisk_out, 4'h1);
        set_rx(ALIGNW, 4'h1);
        tick();
        check_val("rx_copy", rxdata_out, ALIGNW);
        check_val("align_hold", oob_state, 3'd4);
        set_rx(SYNCW, 4'h1);
        tick();
        check_val("sync_state", oob_state, 3'd5);
        check_val("sync_tx", txdata_out, SYNCW);
        tick();
        tick();
        check_val("sync_pre", link_up, 1'b0);
        tick();
        check_val("linkup", link_up, 1'b1);
        check_val("linkup_state", oob_state, 3'd6);
        check_val("linkup_pass0", txdata_out, 32'hDEADBEEF);
        check_val("linkup_passk0", txcharisk_out, 4'hF);
        txdata_in    = 32'h12345678;
        txcharisk_in = 4'h3;
        tick();
        check_val("linkup_pass1", txdata_out, 32'h12345678);
        check_val("linkup_passk1", txcharisk_out, 4'h3);

        // COMINIT while linked: link drops with txcominit 2 cycles later
        rxcominitdet_in = 1'b1;
        tick();
        rxcominitdet_in = 1'b0;
        check_val("loss_lat1", link_up, 1'b1);
        tick();
        check_val("loss_linkup", link_up, 1'b0);
        check_val("loss_cominit", txcominit, 1'b1);
        check_val("loss_state", oob_state, 3'd1);
        check_val("loss_txdata", txdata_out, 32'd0);
        tick();
        check_val("loss_wait", oob_state, 3'd2);

        // SYNC counting cleared by an ALIGNp in the middle
        to_send_align();
        check_val("seq_align", oob_state, 3'd4);
        set_rx(ALIGNW, 4'h1);
        tick();
        set_rx(32'd0, 4'd0);
        tick();
        check_val("seq_sync", oob_state, 3'd5);
        words = '{SYNCW, SYNCW, ALIGNW, SYNCW, SYNCW, SYNCW};
        for (int i = 0; i < 6; i++) begin
            set_rx(words[i], 4'h1);
            tick();
            check_val("seq_partial", link_up, 1'b0);
        end
        tick();
        check_val("seq_linkup", link_up, 1'b1);

        // Async reset while in SEND_ALIGN
        rxcominitdet_in = 1'b1;
        tick();
        rxcominitdet_in = 1'b0;
        tick();
        tick();
        to_send_align();
        check_val("ar_pre_state", oob_state, 3'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("ar_state", oob_state, 3'd0);
        check_val("ar_txdata", txdata_out, 32'd0);
        check_val("ar_txk", txcharisk_out, 4'd0);
        check_val("ar_eidle", txelecidle, 1'b1);
        check_val("ar_rxdata", rxdata_out, 32'd0);
        tick();
        check_val("ar_hold", oob_state, 3'd0);
        rst_n = 1'b1;
        tick();
        check_val("ar_after", oob_state, 3'd0);
        set_rx(32'd0, 4'd0);

        // Timeout in WAIT_COMWAKE: single error pulse, back to IDLE
        rxcominitdet_in = 1'b1;
        tick();
        rxcominitdet_in = 1'b0;
        tick();
        tick();
        check_val("to_wait", oob_state, 3'd2);
        hold_bad = 0;
        for (int i = 0; i < TMO - 1; i++) begin
            tick();
            if ((oob_state != 3'd2) || (oob_error != 1'b0)) hold_bad++;
        end
        check_val("to_hold", hold_bad, 0);
        tick();
        check_val("to_err_state", oob_state, 3'd7);
        check_val("to_err_pulse", oob_error, 1'b1);
        check_val("to_err_eidle", txelecidle, 1'b1);
        tick();
        check_val("to_idle", oob_state, 3'd0);
        check_val("to_pulse_end", oob_error, 1'b0);
        check_val("to_idle_eidle", txelecidle, 1'b1);
        repeat (3) tick();
        check_val("to_no_repeat", oob_error, 1'b0);

        // dev_start from IDLE, ignored elsewhere; COMINIT beats simultaneous timeout
        dev_start = 1'b1;
        tick();
        dev_start = 1'b0;
        check_val("ds_cominit", txcominit, 1'b1);
        tick();
        check_val("ds_wait", oob_state, 3'd2);
        dev_start = 1'b1;
        tick();
        dev_start = 1'b0;
        check_val("ds_ignored", oob_state, 3'd2);
        repeat (TMO - 3) tick();
        rxcominitdet_in = 1'b1;
        tick();
        rxcominitdet_in = 1'b0;
        check_val("prio_pre", oob_state, 3'd2);
        tick();
        check_val("prio_state", oob_state, 3'd1);
        check_val("prio_cominit", txcominit, 1'b1);
        check_val("prio_noerr", oob_error, 1'b0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
